// File: rtl/vga_stripe_disp_pkg.sv
// Shared VGA timing helpers, 640x480 defaults and the RGB pixel type.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 1;

  typedef logic [3*DEF_COLOR_W-1:0] rgb_t;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync - 1;
  endfunction
endpackage

// File: rtl/vga_stripe_disp_if.sv
// Palette/mode controls in, VGA connector signals out.
interface vga_stripe_disp_if #(parameter int COLOR_W = 1);
  logic [COLOR_W-1:0]   r_in;
  logic [COLOR_W-1:0]   g_in;
  logic [COLOR_W-1:0]   b_in;
  logic                 set_pulse;
  logic                 clear;
  logic                 mode;
  logic                 hsync;
  logic                 vsync;
  logic                 disp_on;
  logic [3*COLOR_W-1:0] color;
  logic                 frame_start;

  modport master (
    output r_in, g_in, b_in, set_pulse, clear, mode,
    input  hsync, vsync, disp_on, color, frame_start
  );
  modport slave (
    input  r_in, g_in, b_in, set_pulse, clear, mode,
    output hsync, vsync, disp_on, color, frame_start
  );
endinterface

// File: rtl/vga_stripe_disp_timing.sv
// Pixel divider, h/v counters, raw syncs, active flag and frame-start strobe.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 2,
  localparam int H_TOT   = total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOT   = total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = cw(H_TOT)
) (
  input  logic          sysclk,
  input  logic          reset,
  output logic          pix_en,
  output logic [HW-1:0] hc,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          active,
  output logic          frame_start
);
  localparam int VW   = cw(V_TOT);
  localparam int DW   = cw(CLK_DIV);
  localparam int HS_S = sync_start(H_ACTIVE, H_FP);
  localparam int HS_E = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_S = sync_start(V_ACTIVE, V_FP);
  localparam int VS_E = sync_end(V_ACTIVE, V_FP, V_SYNC);

  logic          run;
  logic [DW-1:0] div_cnt;
  logic [VW-1:0] vc;

  // run holds pix_en off while in reset, which matters when CLK_DIV=1
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      run     <= 1'b0;
      div_cnt <= '0;
    end else begin
      run     <= 1'b1;
      div_cnt <= (div_cnt == DW'(CLK_DIV-1)) ? '0 : div_cnt + 1'b1;
    end
  end

  assign pix_en = run && (div_cnt == DW'(CLK_DIV-1));

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == HW'(H_TOT-1)) begin
        hc <= '0;
        vc <= (vc == VW'(V_TOT-1)) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign hs_raw      = (hc >= HW'(HS_S)) && (hc <= HW'(HS_E));
  assign vs_raw      = (vc >= VW'(VS_S)) && (vc <= VW'(VS_E));
  assign active      = (hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE));
  assign frame_start = pix_en && (hc == '0) && (vc == '0);
endmodule

// File: rtl/vga_stripe_disp.sv
// VGA engine: frame-latched palette shown as a solid colour or equal-width vertical stripes.
module vga_stripe_disp import vga_pkg::*; #(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int CLK_DIV     = 2,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int NUM_STRIPES = 4,
  parameter bit SYNC_POL    = 1'b0
) (
  input logic               sysclk,
  input logic               reset,
  vga_stripe_disp_if.slave  bus
);
  localparam int H_TOT    = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int HW       = cw(H_TOT);
  localparam int STRIPE_W = H_ACTIVE / NUM_STRIPES;
  localparam int SCW      = cw(STRIPE_W);
  localparam int IW       = cw(NUM_STRIPES);

  typedef logic [3*COLOR_W-1:0] pix_t;

  logic          pix_en, hs_raw, vs_raw, active, frame_start;
  logic [HW-1:0] hc;

  pix_t          pal    [NUM_STRIPES];
  pix_t          shadow [NUM_STRIPES];
  pix_t          last_col, shadow_last;
  logic          mode_q;
  logic [IW-1:0] wr_ptr, s_idx;
  logic [SCW-1:0] s_cnt;

  logic          sel_mode;
  pix_t          sel_last, sel_stripe, pix_color;
  logic          hsync_q, vsync_q, disp_q;
  pix_t          color_q;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .sysclk(sysclk), .reset(reset), .pix_en(pix_en), .hc(hc),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .active(active), .frame_start(frame_start)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STRIPES; i++) pal[i] <= '0;
      last_col <= '0;
      wr_ptr   <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_STRIPES; i++) pal[i] <= '0;
      last_col <= '0;
      wr_ptr   <= '0;
    end else if (bus.set_pulse) begin
      pal[wr_ptr] <= {bus.r_in, bus.g_in, bus.b_in};
      last_col    <= {bus.r_in, bus.g_in, bus.b_in};
      wr_ptr      <= (wr_ptr == IW'(NUM_STRIPES-1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STRIPES; i++) shadow[i] <= '0;
      shadow_last <= '0;
      mode_q      <= 1'b0;
    end else if (frame_start) begin
      shadow      <= pal;
      shadow_last <= last_col;
      mode_q      <= bus.mode;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s_cnt <= '0;
      s_idx <= '0;
    end else if (pix_en) begin
      if (hc == HW'(H_TOT-1)) begin
        s_cnt <= '0;
        s_idx <= '0;
      end else if (hc < HW'(H_ACTIVE)) begin
        if (s_cnt == SCW'(STRIPE_W-1)) begin
          s_cnt <= '0;
          if (s_idx != IW'(NUM_STRIPES-1)) s_idx <= s_idx + 1'b1;
        end else begin
          s_cnt <= s_cnt + 1'b1;
        end
      end
    end
  end

  // Pixel (0,0) is rendered in the latch cycle itself, so it reads the values being latched
  always_comb begin
    sel_mode   = frame_start ? bus.mode : mode_q;
    sel_last   = frame_start ? last_col : shadow_last;
    sel_stripe = frame_start ? pal[s_idx] : shadow[s_idx];
    pix_color  = '0;
    if (active) pix_color = sel_mode ? sel_stripe : sel_last;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      disp_q  <= 1'b0;
      color_q <= '0;
    end else if (pix_en) begin
      hsync_q <= hs_raw ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_raw ? SYNC_POL : ~SYNC_POL;
      disp_q  <= active;
      color_q <= pix_color;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.disp_on     = disp_q;
  assign bus.color       = color_q;
  assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_vga_stripe_disp.sv
// Bench for vga_stripe_disp on a tiny 14x7 raster; reference model works from elapsed clock count.
module tb_vga_stripe_disp;
  localparam int HT = 14;
  localparam int FR = HT * 7;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  vga_stripe_disp_if #(.COLOR_W(1)) vif();

  vga_stripe_disp #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .COLOR_W(1), .NUM_STRIPES(4), .SYNC_POL(1'b0)
  ) dut (.sysclk(sysclk), .reset(reset), .bus(vif));

  always #5 sysclk = ~sysclk;

  // Model: m = rising edges since reset release; 2 edges per pixel, outputs one pixel late
  int unsigned m;
  logic [2:0]  pal_m [4];
  logic [2:0]  snap_pal [4];
  logic [2:0]  last_m, snap_last;
  logic        snap_mode;
  int          wptr_m;

  function automatic logic fs_now();
    return reset && (m % 2 == 1) && (((m - 1) / 2) % FR == 0);
  endfunction

  function automatic int shown_k();
    return (!reset || m < 2) ? -1 : int'(m / 2) - 1;
  endfunction

  always @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      m <= 0; last_m <= 3'b0; snap_last <= 3'b0; snap_mode <= 1'b0; wptr_m <= 0;
      for (int i = 0; i < 4; i++) begin pal_m[i] <= 3'b0; snap_pal[i] <= 3'b0; end
    end else begin
      if (fs_now()) begin
        snap_pal <= pal_m; snap_last <= last_m; snap_mode <= vif.mode;
      end
      if (vif.clear) begin
        for (int i = 0; i < 4; i++) pal_m[i] <= 3'b0;
        last_m <= 3'b0; wptr_m <= 0;
      end else if (vif.set_pulse) begin
        pal_m[wptr_m] <= {vif.r_in, vif.g_in, vif.b_in};
        last_m <= {vif.r_in, vif.g_in, vif.b_in};
        wptr_m <= (wptr_m + 1) % 4;
      end
      m <= m + 1;
    end
  end

  // {hsync, vsync, disp_on, frame_start, color}
  function automatic logic [6:0] exp_vec();
    int k, hc, vc;
    logic hs, vs, de;
    logic [2:0] c;
    k = shown_k();
    if (k < 0) return {1'b1, 1'b1, 1'b0, fs_now(), 3'b0};
    hc = k % HT;
    vc = (k / HT) % 7;
    hs = !(hc >= 10 && hc <= 11);
    vs = (vc != 5);
    de = (hc < 8) && (vc < 4);
    c  = de ? (snap_mode ? snap_pal[hc / 2] : snap_last) : 3'b0;
    return {hs, vs, de, fs_now(), c};
  endfunction

  function automatic logic [6:0] obs();
    return {vif.hsync, vif.vsync, vif.disp_on, vif.frame_start, vif.color};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge sysclk);
      checks++;
      if (obs() !== 7'b1100_000) begin
        fails++; $display("FAIL reset_state: got %b want %b", obs(), 7'b1100_000);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_sync();
    int hl = 0, vl = 0, fsn = 0;
    logic [6:0] ev;
    for (int n = 0; n < 4 * FR; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL sync_model: got %b want %b m=%0d", obs(), ev, m); end
      hl += int'(!vif.hsync); vl += int'(!vif.vsync); fsn += int'(vif.frame_start);
    end
    checks++; if (hl != 56) begin fails++; $display("FAIL hsync_low_cycles: got %0d want 56", hl); end
    checks++; if (vl != 56) begin fails++; $display("FAIL vsync_low_cycles: got %0d want 56", vl); end
    checks++; if (fsn != 2) begin fails++; $display("FAIL frame_start_count: got %0d want 2", fsn); end
  endtask

  task automatic test_stripes();
    logic [2:0] cols [4];
    logic [6:0] ev;
    int f0 = -1, nset = 0, seen = 0, k;
    cols = '{3'b001, 3'b010, 3'b100, 3'b111};
    for (int n = 0; n < 700; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL stripes_model: got %b want %b m=%0d", obs(), ev, m); end
      k = shown_k();
      vif.set_pulse = 1'b0;
      if (f0 >= 0 && k / FR == f0 && vif.disp_on) begin
        checks++; if (vif.color !== 3'b000) begin fails++; $display("FAIL stripes_cur_black: got %b want 000", vif.color); end
      end
      if (f0 >= 0 && k / FR == f0 + 1 && k % FR < 8) begin
        seen++; checks++;
        if (vif.color !== cols[(k % FR) / 2]) begin
          fails++; $display("FAIL stripes_next: got %b want %b hc=%0d", vif.color, cols[(k % FR) / 2], k % FR);
        end
      end
      if (nset < 4 && k >= 0 && (k % FR) / HT == 1) begin
        if (f0 < 0) f0 = k / FR;
        {vif.r_in, vif.g_in, vif.b_in} = cols[nset];
        vif.set_pulse = 1'b1; vif.mode = 1'b1; nset++;
      end
    end
    checks++; if (seen != 16) begin fails++; $display("FAIL stripes_seen: got %0d want 16", seen); end
  endtask

  task automatic test_wrap_solid();
    logic [2:0] cols [4];
    logic [6:0] ev;
    int f0 = -1, solid = 0, k;
    cols = '{3'b110, 3'b010, 3'b100, 3'b111};
    for (int n = 0; n < 900; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL wrap_model: got %b want %b m=%0d", obs(), ev, m); end
      k = shown_k();
      vif.set_pulse = 1'b0;
      if (f0 >= 0 && k / FR == f0 + 1 && vif.disp_on) begin
        solid++; checks++;
        if (vif.color !== 3'b110) begin fails++; $display("FAIL solid_line: got %b want 110", vif.color); end
      end
      if (f0 >= 0 && k / FR == f0 + 2 && k % FR < 8) begin
        checks++;
        if (vif.color !== cols[(k % FR) / 2]) begin
          fails++; $display("FAIL wrap_pal0: got %b want %b", vif.color, cols[(k % FR) / 2]);
        end
      end
      if (f0 < 0 && k >= 0 && (k % FR) / HT == 1) begin
        f0 = k / FR;
        {vif.r_in, vif.g_in, vif.b_in} = 3'b110;
        vif.set_pulse = 1'b1; vif.mode = 1'b0;
      end
      if (f0 >= 0 && k / FR == f0 + 1 && (k % FR) / HT == 1) vif.mode = 1'b1;
    end
    checks++; if (solid != 64) begin fails++; $display("FAIL solid_count: got %0d want 64", solid); end
  endtask

  task automatic test_clear();
    logic [6:0] ev;
    int f0 = -1, dark = 0, k;
    bit resent = 0;
    for (int n = 0; n < 900; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL clear_model: got %b want %b m=%0d", obs(), ev, m); end
      k = shown_k();
      vif.set_pulse = 1'b0; vif.clear = 1'b0;
      if (f0 >= 0 && k / FR == f0 + 1 && vif.disp_on) begin
        dark++; checks++;
        if (vif.color !== 3'b000) begin fails++; $display("FAIL clear_black: got %b want 000", vif.color); end
      end
      if (f0 >= 0 && k / FR == f0 + 2 && k % FR < 8) begin
        checks++;
        if (vif.color !== ((k % FR) < 2 ? 3'b011 : 3'b000)) begin
          fails++; $display("FAIL clear_wrptr: got %b hc=%0d", vif.color, k % FR);
        end
      end
      if (f0 < 0 && k >= 0 && (k % FR) / HT == 1) begin
        f0 = k / FR;
        {vif.r_in, vif.g_in, vif.b_in} = 3'b111;
        vif.set_pulse = 1'b1; vif.clear = 1'b1; vif.mode = 1'b1;
      end else if (!resent && f0 >= 0 && k / FR == f0 + 1 && (k % FR) / HT == 1) begin
        resent = 1;
        {vif.r_in, vif.g_in, vif.b_in} = 3'b011;
        vif.set_pulse = 1'b1;
      end
    end
    checks++; if (dark != 64) begin fails++; $display("FAIL clear_count: got %0d want 64", dark); end
  endtask

  task automatic test_frame_edge();
    logic [6:0] ev;
    logic [2:0] want;
    int f0 = -1, k, after = -1;
    for (int n = 0; n < 700; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL edge_model: got %b want %b m=%0d", obs(), ev, m); end
      k = shown_k();
      vif.set_pulse = 1'b0;
      if (after == n) begin
        checks++; if (vif.frame_start !== 1'b0) begin fails++; $display("FAIL fs_width: got %b want 0", vif.frame_start); end
      end
      if (f0 >= 0 && k >= 0 && (k / FR == f0 || k / FR == f0 + 1) && k % FR < 8) begin
        want = ((k % FR) < 2) ? 3'b011 : ((k % FR) < 4 && k / FR == f0 + 1) ? 3'b101 : 3'b000;
        checks++;
        if (vif.color !== want) begin fails++; $display("FAIL edge_visible: got %b want %b k=%0d", vif.color, want, k); end
      end
      if (f0 < 0 && n > 4 && fs_now()) begin
        checks++; if (vif.frame_start !== 1'b1) begin fails++; $display("FAIL fs_high: got %b want 1", vif.frame_start); end
        f0 = int'((m - 1) / 2) / FR; after = n + 1;
        {vif.r_in, vif.g_in, vif.b_in} = 3'b101;
        vif.set_pulse = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ev;
    for (int n = 0; n < 4 * 2 * FR; n++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL random_model: got %b want %b m=%0d", obs(), ev, m); end
      {vif.r_in, vif.g_in, vif.b_in} = 3'($urandom_range(0, 7));
      vif.set_pulse = ($urandom_range(0, 7) == 0);
      vif.clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) vif.mode = ~vif.mode;
    end
    vif.set_pulse = 1'b0; vif.clear = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [6:0] ev;
    int n = 0;
    while (n < 400 && !(shown_k() >= 0 && shown_k() % FR == 2 * HT + 5)) begin
      @(negedge sysclk); n++;
    end
    checks++; if (n >= 400) begin fails++; $display("FAIL mid_reset_reach: got timeout want hc=5,vc=2"); end
    reset = 1'b0;
    #1;
    checks++; if (obs() !== 7'b1100_000) begin fails++; $display("FAIL mid_reset_now: got %b want 1100000", obs()); end
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    for (int i = 0; i < 2 * FR + 10; i++) begin
      @(negedge sysclk);
      ev = exp_vec(); checks++;
      if (obs() !== ev) begin fails++; $display("FAIL mid_reset_model: got %b want %b m=%0d", obs(), ev, m); end
      if (i == 0) begin
        checks++; if (vif.frame_start !== 1'b1) begin fails++; $display("FAIL mid_reset_first_fs: got %b want 1", vif.frame_start); end
      end
    end
  endtask

  initial begin
    vif.r_in = 1'b0; vif.g_in = 1'b0; vif.b_in = 1'b0;
    vif.set_pulse = 1'b0; vif.clear = 1'b0; vif.mode = 1'b0;
    #1;
    test_reset();
    test_sync();
    test_stripes();
    test_wrap_solid();
    test_clear();
    test_frame_edge();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
